// File: rtl/bus_arbiter_pkg.sv
// Shared bus-owner types and grant levels for the four-master round-robin arbiter.
package bus_arbiter_pkg;

    typedef logic [1:0] BusOwnerBus;

    localparam BusOwnerBus BUS_OWNER_MASTER_0 = 2'd0;
    localparam BusOwnerBus BUS_OWNER_MASTER_1 = 2'd1;
    localparam BusOwnerBus BUS_OWNER_MASTER_2 = 2'd2;
    localparam BusOwnerBus BUS_OWNER_MASTER_3 = 2'd3;

    // Grant pins are active-low.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    function automatic logic [3:0] rotate_right(input logic [3:0] v, input BusOwnerBus amt);
        logic [7:0] doubled;
        doubled = {v, v} >> amt;
        return doubled[3:0];
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate so the slot after the last owner is
// bit 0, take the lowest set bit among the other three masters, then un-rotate.
module rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic [3:0] req,
    input  BusOwnerBus last,
    output BusOwnerBus next_idx,
    output logic       valid
);

    BusOwnerBus start;
    BusOwnerBus offset;
    logic [3:0] rot;

    // rot[3] is the last owner itself, so it is deliberately never considered.
    always_comb begin
        start  = last + 2'd1;
        rot    = rotate_right(req, start);
        valid  = 1'b0;
        offset = 2'd0;
        if (rot[0]) begin
            valid  = 1'b1;
            offset = 2'd0;
        end else if (rot[1]) begin
            valid  = 1'b1;
            offset = 2'd1;
        end else if (rot[2]) begin
            valid  = 1'b1;
            offset = 2'd2;
        end
        next_idx = start + offset;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with active-low handshakes, a parked
// owner register and a sticky hold-time watchdog.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output BusOwnerBus owner,
    input  logic       wd_clr,
    output logic       wd_err,
    output BusOwnerBus wd_master
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [3:0]       req_act;
    BusOwnerBus       pick_idx;
    logic             pick_valid;
    logic             owner_req;
    logic             trip;

    BusOwnerBus       owner_q, owner_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             sat_q, sat_d;
    logic             wd_err_q, wd_err_d;
    BusOwnerBus       wd_master_q, wd_master_d;

    assign req_act   = ~{m3_req_, m2_req_, m1_req_, m0_req_};
    assign owner_req = req_act[owner_q];

    rr_pick u_rr_pick (
        .req      (req_act),
        .last     (owner_q),
        .next_idx (pick_idx),
        .valid    (pick_valid)
    );

    // Owner is held while it requests; otherwise hand over or stay parked.
    // sat_q remembers that the counter already sat at the limit last cycle,
    // so the watchdog trips only on the first saturated cycle.
    always_comb begin
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        if (owner_req) begin
            if (hold_cnt_q != TIMEOUT_CNT) begin
                hold_cnt_d = hold_cnt_q + CNT_ONE;
            end
        end else if (pick_valid) begin
            owner_d    = pick_idx;
            hold_cnt_d = CNT_ONE;
        end else begin
            hold_cnt_d = '0;
        end

        sat_d       = (hold_cnt_q == TIMEOUT_CNT);
        trip        = sat_d && !sat_q;
        wd_err_d    = wd_err_q;
        wd_master_d = wd_master_q;
        if (trip) begin
            wd_err_d    = 1'b1;
            wd_master_d = owner_q;
        end else if (wd_clr) begin
            wd_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q     <= BUS_OWNER_MASTER_0;
            hold_cnt_q  <= '0;
            sat_q       <= 1'b0;
            wd_err_q    <= 1'b0;
            wd_master_q <= BUS_OWNER_MASTER_0;
        end else begin
            owner_q     <= owner_d;
            hold_cnt_q  <= hold_cnt_d;
            sat_q       <= sat_d;
            wd_err_q    <= wd_err_d;
            wd_master_q <= wd_master_d;
        end
    end

    assign m0_grnt_  = (owner_q == BUS_OWNER_MASTER_0) ? ENABLE_ : DISABLE_;
    assign m1_grnt_  = (owner_q == BUS_OWNER_MASTER_1) ? ENABLE_ : DISABLE_;
    assign m2_grnt_  = (owner_q == BUS_OWNER_MASTER_2) ? ENABLE_ : DISABLE_;
    assign m3_grnt_  = (owner_q == BUS_OWNER_MASTER_3) ? ENABLE_ : DISABLE_;
    assign owner     = owner_q;
    assign wd_err    = wd_err_q;
    assign wd_master = wd_master_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random request
// traffic, all compared cycle by cycle against a behavioural arbiter model.
module tb_bus_arbiter;

    localparam int TB_TIMEOUT = 8;
    localparam int TB_CNT_W   = 4;

    logic       clk;
    logic       reset;
    logic       m0_req_, m1_req_, m2_req_, m3_req_;
    logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    logic [1:0] owner;
    logic       wd_clr;
    logic       wd_err;
    logic [1:0] wd_master;
    logic [3:0] grnt;

    int num_tests;
    int num_fails;

    // Reference model state: plain integers, rules applied directly.
    int m_owner;
    int m_cnt;
    int m_prev_cnt;
    int m_err;
    int m_wmaster;
    logic [3:0] cur_act;

    bus_arbiter #(.TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req_   (m0_req_),
        .m1_req_   (m1_req_),
        .m2_req_   (m2_req_),
        .m3_req_   (m3_req_),
        .m0_grnt_  (m0_grnt_),
        .m1_grnt_  (m1_grnt_),
        .m2_grnt_  (m2_grnt_),
        .m3_grnt_  (m3_grnt_),
        .owner     (owner),
        .wd_clr    (wd_clr),
        .wd_err    (wd_err),
        .wd_master (wd_master)
    );

    assign grnt = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_tests++;
        if (got !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] act, input logic clr);
        cur_act = act;
        m0_req_ = ~act[0];
        m1_req_ = ~act[1];
        m2_req_ = ~act[2];
        m3_req_ = ~act[3];
        wd_clr  = clr;
    endtask

    task automatic model_reset();
        m_owner    = 0;
        m_cnt      = 0;
        m_prev_cnt = 0;
        m_err      = 0;
        m_wmaster  = 0;
    endtask

    task automatic model_step(input logic [3:0] act, input logic clr);
        int  old_cnt;
        bit  found;
        old_cnt = m_cnt;
        if (m_cnt == TB_TIMEOUT && m_prev_cnt != TB_TIMEOUT) begin
            m_err     = 1;
            m_wmaster = m_owner;
        end else if (clr) begin
            m_err = 0;
        end
        if (act[m_owner]) begin
            m_cnt = (m_cnt < TB_TIMEOUT) ? m_cnt + 1 : TB_TIMEOUT;
        end else begin
            found = 0;
            for (int k = 1; k <= 3; k++) begin
                if (!found && act[(m_owner + k) % 4]) begin
                    m_owner = (m_owner + k) % 4;
                    found   = 1;
                end
            end
            m_cnt = found ? 1 : 0;
        end
        m_prev_cnt = old_cnt;
    endtask

    task automatic check_all();
        logic [3:0] exp_g;
        exp_g = 4'b1111;
        exp_g[m_owner] = 1'b0;
        check_output("owner", 32'(owner), 32'(m_owner));
        check_output("grants", 32'(grnt), 32'(exp_g));
        check_output("one_grant", $countones(~grnt), 1);
        check_output("wd_err", 32'(wd_err), 32'(m_err));
        check_output("wd_master", 32'(wd_master), 32'(m_wmaster));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(cur_act, wd_clr);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        apply_stimulus(4'b0000, 1'b0);
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check_output("rst_hold_cnt", 32'(dut.hold_cnt_q), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int         order[$];
        int         exp_order[3];
        int         prev_owner;
        int         last_m;
        int         held;
        int         first_err;
        logic [3:0] act;

        num_tests = 0;
        num_fails = 0;
        exp_order = '{0, 1, 2};
        reset = 1'b1;
        apply_stimulus(4'b0000, 1'b0);
        #2;
        do_reset();

        // Reset and parking: idle for ten cycles, master 0 stays granted.
        for (int i = 0; i < 10; i++) begin
            tick();
            check_output("park_owner", 32'(owner), 0);
        end

        // Single non-owner request: one-cycle grant, then parks on master 2.
        apply_stimulus(4'b0100, 1'b0);
        tick();
        check_output("m2_grant", 32'(m2_grnt_), 0);
        check_output("m2_owner", 32'(owner), 2);
        apply_stimulus(4'b0000, 1'b0);
        repeat (3) tick();
        check_output("m2_parked", 32'(owner), 2);

        // Rotation from owner 3 with masters 0, 1, 2 all requesting.
        apply_stimulus(4'b1000, 1'b0);
        repeat (2) tick();
        check_output("rot_start", 32'(owner), 3);
        act = 4'b0111;
        apply_stimulus(act, 1'b0);
        prev_owner = int'(owner);
        last_m = m_owner;
        held = 0;
        for (int c = 0; c < 60 && act != 4'b0000; c++) begin
            tick();
            if (int'(owner) != prev_owner) begin
                order.push_back(int'(owner));
                prev_owner = int'(owner);
            end
            if (m_owner != last_m) begin
                held = 0;
                last_m = m_owner;
            end
            if (act[m_owner]) begin
                held++;
                if (held == 4) begin
                    act[m_owner] = 1'b0;
                    apply_stimulus(act, 1'b0);
                end
            end
        end
        check_output("rot_done", 32'(act), 0);
        check_output("rot_count", order.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check_output("rot_order", (order.size() > i) ? order[i] : -1, exp_order[i]);
        end

        // Fairness: master 1 drops and immediately re-requests while 2 waits.
        apply_stimulus(4'b0010, 1'b0);
        repeat (2) tick();
        check_output("fair_start", 32'(owner), 1);
        apply_stimulus(4'b0110, 1'b0);
        tick();
        apply_stimulus(4'b0100, 1'b0);
        tick();
        apply_stimulus(4'b0110, 1'b0);
        tick();
        check_output("fair_m2_first", 32'(owner), 2);
        apply_stimulus(4'b0010, 1'b0);
        tick();
        check_output("fair_m1_after", 32'(owner), 1);

        // Watchdog: master 1 holds for 20 cycles from a parked master 0.
        do_reset();
        apply_stimulus(4'b0010, 1'b0);
        first_err = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (wd_err && first_err < 0) first_err = k;
        end
        check_output("wd_first_cycle", first_err, TB_TIMEOUT + 1);
        check_output("wd_err_set", 32'(wd_err), 1);
        check_output("wd_master_1", 32'(wd_master), 1);
        check_output("wd_grant_kept", 32'(m1_grnt_), 0);
        apply_stimulus(4'b0000, 1'b0);
        tick();
        apply_stimulus(4'b0000, 1'b1);
        tick();
        apply_stimulus(4'b0000, 1'b0);
        tick();
        check_output("wd_cleared", 32'(wd_err), 0);

        // Repeat with wd_clr coinciding with the trip cycle: trip must win.
        apply_stimulus(4'b0010, 1'b0);
        for (int k = 0; k < 30 && !(m_cnt == TB_TIMEOUT && m_prev_cnt != TB_TIMEOUT); k++) begin
            tick();
        end
        apply_stimulus(4'b0010, 1'b1);
        tick();
        check_output("wd_trip_wins", 32'(wd_err), 1);
        apply_stimulus(4'b0010, 1'b0);
        tick();
        apply_stimulus(4'b0000, 1'b0);
        tick();

        // Reset mid-operation while master 3 owns the bus.
        apply_stimulus(4'b1000, 1'b0);
        repeat (3) tick();
        check_output("mid_owner3", 32'(owner), 3);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        check_output("mid_grants", 32'(grnt), 32'(4'b1110));
        check_output("mid_hold_cnt", 32'(dut.hold_cnt_q), 0);
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(4'b0000, 1'b0);

        // Random traffic: each request flips with low probability so holds
        // last long enough to exercise the watchdog.
        act = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) act[b] = ~act[b];
            end
            apply_stimulus(act, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", num_tests, num_fails);
        $finish;
    end

endmodule
